// File: rtl/rf_pkg.sv
// Shared register-file definitions for the operand fetch slice: default sizes,
// the hard-wired zero register and the index/word types.
package rf_pkg;

   localparam int NREGS      = 32;
   localparam int XLEN       = 32;
   localparam int LOG2_NREGS = $clog2(NREGS);

   typedef logic [LOG2_NREGS-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]       xword_t;

   localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write scoreboard with three busy lookups. A register
// is reported busy only if its pending write is not being retired this cycle.
module reg_scoreboard
   import rf_pkg::*;
#(
   parameter int nregs      = NREGS,
   parameter int log2_nregs = LOG2_NREGS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [log2_nregs-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [log2_nregs-1:0] clr_idx,
   input  logic [log2_nregs-1:0] query_a,
   input  logic [log2_nregs-1:0] query_b,
   input  logic [log2_nregs-1:0] query_c,
   output logic                  busy_a,
   output logic                  busy_b,
   output logic                  busy_c
);

   logic [nregs-1:0] pending;
   logic [nregs-1:0] pending_next;

   function automatic logic lookup(input logic [nregs-1:0]      pend,
                                   input logic [log2_nregs-1:0] idx,
                                   input logic                  wb_en,
                                   input logic [log2_nregs-1:0] wb_idx);
      logic wb_hit;
      wb_hit = wb_en && (wb_idx == idx);
      return (idx != ZERO_REG) && pend[idx] && !wb_hit;
   endfunction

   assign busy_a = lookup(pending, query_a, clr_en, clr_idx);
   assign busy_b = lookup(pending, query_b, clr_en, clr_idx);
   assign busy_c = lookup(pending, query_c, clr_en, clr_idx);

   // The set is applied after the clear so a new producer stays outstanding
   // when the old one retires on the same edge.
   always_comb begin
      // NOTE: default every comb output first so no path leaves it unassigned (no latch).
      pending_next = pending;
      if (clr_en && clr_idx != ZERO_REG)
         pending_next[clr_idx] = 1'b0;
      if (set_en && set_idx != ZERO_REG)
         pending_next[set_idx] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset)
         pending <= '0;
      else
         pending <= pending_next;
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, bypasses same-cycle writeback, stalls
// on RAW/WAW hazards and registers the operand bundle for execute.
module operand_fetch_stage
   import rf_pkg::*;
#(
   parameter int nregs      = NREGS,
   parameter int xlen       = XLEN,
   parameter int log2_nregs = $clog2(nregs)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [log2_nregs-1:0] in_rs1,
   input  logic [log2_nregs-1:0] in_rs2,
   input  logic [log2_nregs-1:0] in_rd,
   input  logic                  in_rd_we,
   output logic [log2_nregs-1:0] rf_read_addr1,
   output logic [log2_nregs-1:0] rf_read_addr2,
   input  logic [xlen-1:0]       rf_read_data1,
   input  logic [xlen-1:0]       rf_read_data2,
   input  logic                  wb_valid,
   input  logic [log2_nregs-1:0] wb_addr,
   input  logic [xlen-1:0]       wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [xlen-1:0]       out_rs1_data,
   output logic [xlen-1:0]       out_rs2_data,
   output logic [log2_nregs-1:0] out_rd,
   output logic                  out_rd_we
);

   logic            busy_rs1;
   logic            busy_rs2;
   logic            busy_rd;
   logic            hazard;
   logic            accept;
   logic            rd_writes;
   logic [xlen-1:0] operand1;
   logic [xlen-1:0] operand2;

   assign rf_read_addr1 = in_rs1;
   assign rf_read_addr2 = in_rs2;

   assign rd_writes = in_rd_we && (in_rd != ZERO_REG);

   reg_scoreboard #(
      .nregs      (nregs),
      .log2_nregs (log2_nregs)
   ) u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .set_en  (accept && rd_writes),
      .set_idx (in_rd),
      .clr_en  (wb_valid),
      .clr_idx (wb_addr),
      .query_a (in_rs1),
      .query_b (in_rs2),
      .query_c (in_rd),
      .busy_a  (busy_rs1),
      .busy_b  (busy_rs2),
      .busy_c  (busy_rd)
   );

   assign hazard   = in_valid && (busy_rs1 || busy_rs2 || (in_rd_we && busy_rd));
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   function automatic logic [xlen-1:0] select_operand(input logic [log2_nregs-1:0] rs,
                                                      input logic [xlen-1:0]       rf_data,
                                                      input logic                  wb_en,
                                                      input logic [log2_nregs-1:0] wb_idx,
                                                      input logic [xlen-1:0]       wb_value);
      if (rs == ZERO_REG)
         return '0;
      else if (wb_en && wb_idx == rs)
         return wb_value;
      else
         return rf_data;
   endfunction

   assign operand1 = select_operand(in_rs1, rf_read_data1, wb_valid, wb_addr, wb_data);
   assign operand2 = select_operand(in_rs2, rf_read_data2, wb_valid, wb_addr, wb_data);

   // Without an accept the bundle either holds (stalled downstream) or drains.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_rd_we    <= 1'b0;
         out_rd       <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_rd_we    <= rd_writes;
         out_rd       <= in_rd;
         out_rs1_data <= operand1;
         out_rs2_data <= operand2;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, bypass, zero register,
// backpressure, scoreboard set-over-clear and WAW stalls.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rd_we;
   logic [4:0]  rf_read_addr1, rf_read_addr2;
   logic [31:0] rf_read_data1, rf_read_data2;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rs1_data, out_rs2_data;
   logic [4:0]  out_rd;
   logic        out_rd_we;

   int checks = 0;
   int errors = 0;

   operand_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rs1        (in_rs1),
      .in_rs2        (in_rs2),
      .in_rd         (in_rd),
      .in_rd_we      (in_rd_we),
      .rf_read_addr1 (rf_read_addr1),
      .rf_read_addr2 (rf_read_addr2),
      .rf_read_data1 (rf_read_data1),
      .rf_read_data2 (rf_read_data2),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rs1_data  (out_rs1_data),
      .out_rs2_data  (out_rs2_data),
      .out_rd        (out_rd),
      .out_rd_we     (out_rd_we)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one edge and settle; inputs are changed only after this returns.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we);
      in_valid = v;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_rd    = rd;
      in_rd_we = we;
      #1;
   endtask

   task automatic writeback(input logic v, input logic [4:0] addr, input logic [31:0] data);
      wb_valid = v;
      wb_addr  = addr;
      wb_data  = data;
   endtask

   initial begin
      reset = 1'b1;
      out_ready = 1'b1;
      rf_read_data1 = '0;
      rf_read_data2 = '0;
      writeback(1'b0, 5'd0, 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;

      // 1: reset mid-stream with a held bundle and a pending register
      rf_read_data1 = 32'h11;
      rf_read_data2 = 32'h22;
      drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
      tick();
      check("pre_reset_valid", out_valid, 1);
      check("pre_reset_rs1", out_rs1_data, 32'h11);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_rd_we", out_rd_we, 0);
      check("rst_out_rs1", out_rs1_data, 0);
      check("rst_out_rs2", out_rs2_data, 0);
      drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
      check("rst_pending9_clear", in_ready, 1);
      check("rd_addr1_passthru", rf_read_addr1, 9);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

      // 2: RAW stall on rd=5 released by a same-cycle bypassed writeback
      rf_read_data1 = 32'h55;
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
      check("issue_rd5_ready", in_ready, 1);
      tick();
      check("issue_rd5_out_rd", out_rd, 5);
      check("issue_rd5_we", out_rd_we, 1);
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
      check("raw5_stall", in_ready, 0);
      tick();
      check("raw5_drain", out_valid, 0);
      check("raw5_stall_held", in_ready, 0);
      writeback(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      check("raw5_wb_release", in_ready, 1);
      tick();
      check("raw5_valid", out_valid, 1);
      check("raw5_bypass", out_rs1_data, 32'hDEADBEEF);
      writeback(1'b0, 5'd0, 32'd0);
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
      check("pending5_cleared", in_ready, 1);

      // 3: zero register reads and writes
      rf_read_data1 = 32'hFFFFFFFF;
      rf_read_data2 = 32'hFFFFFFFF;
      writeback(1'b1, 5'd0, 32'd7);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      tick();
      check("zero_rs1", out_rs1_data, 0);
      check("zero_rs2", out_rs2_data, 0);
      check("zero_rd_we", out_rd_we, 0);
      writeback(1'b0, 5'd0, 32'd0);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      check("zero_no_pending", in_ready, 1);
      writeback(1'b1, 5'd13, 32'h0000CAFE);
      drive(1'b1, 5'd12, 5'd13, 5'd0, 1'b0);
      tick();
      check("nonpend_rf_rs1", out_rs1_data, 32'hFFFFFFFF);
      check("nonpend_bypass_rs2", out_rs2_data, 32'h0000CAFE);
      writeback(1'b0, 5'd0, 32'd0);

      // 4: backpressure hold, then back-to-back accepts
      rf_read_data1 = 32'hA1A1;
      rf_read_data2 = 32'hB2B2;
      drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b0);
      tick();
      out_ready = 1'b0;
      rf_read_data1 = 32'hC3C3;
      drive(1'b1, 5'd3, 5'd2, 5'd8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("hold_in_ready", in_ready, 0);
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_rs1", out_rs1_data, 32'hA1A1);
         check("hold_rd", out_rd, 6);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      tick();
      check("b2b_first_rs1", out_rs1_data, 32'hC3C3);
      check("b2b_first_rd", out_rd, 8);
      rf_read_data1 = 32'hD4D4;
      drive(1'b1, 5'd4, 5'd2, 5'd10, 1'b0);
      check("b2b_ready", in_ready, 1);
      tick();
      check("b2b_second_rs1", out_rs1_data, 32'hD4D4);
      check("b2b_second_rd", out_rd, 10);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      check("drain_valid", out_valid, 0);

      // 5: set wins over clear on register 7
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
      tick();
      writeback(1'b1, 5'd7, 32'h1);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
      check("waw7_masked_by_wb", in_ready, 1);
      tick();
      writeback(1'b0, 5'd0, 32'd0);
      drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
      check("set_wins_stall", in_ready, 0);
      tick();
      check("set_wins_stall_held", in_ready, 0);
      writeback(1'b1, 5'd7, 32'h77777777);
      #1;
      check("rs2_7_release", in_ready, 1);
      tick();
      check("rs2_7_bypass", out_rs2_data, 32'h77777777);
      writeback(1'b0, 5'd0, 32'd0);

      // 6: WAW stall on rd=3 while independent bundles flow at full rate
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
      tick();
      drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b1);
      check("indep_ready_a", in_ready, 1);
      tick();
      check("indep_rd4", out_rd, 4);
      drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b0);
      check("indep_ready_b", in_ready, 1);
      tick();
      check("indep_rd11", out_rd, 11);
      check("indep_valid", out_valid, 1);
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
      check("waw3_stall", in_ready, 0);
      tick();
      check("waw3_drain", out_valid, 0);
      writeback(1'b1, 5'd3, 32'h3);
      #1;
      check("waw3_release", in_ready, 1);
      tick();
      check("waw3_out_rd", out_rd, 3);
      check("waw3_out_we", out_rd_we, 1);
      writeback(1'b0, 5'd0, 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
